// File: rtl/volt_pkg.sv
// Shared types and scaling constants for the voltage sample sequencer.
// Scaling maps a 12-bit average onto 0.00..5.00 V in hundredths.
package volt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_TICK = 3'd1,
        ST_REQ       = 3'd2,
        ST_DIV       = 3'd3,
        ST_BCD       = 3'd4,
        ST_PUBLISH   = 3'd5
    } state_e;

    localparam int SCALE_MUL = 500;
    localparam int SCALE_DIV = 4094;
    localparam int DIV_STEPS = 21;

endpackage

// File: rtl/volt_sample_sequencer_div.sv
// Restoring divider, one quotient bit per cycle; the first step runs in the start cycle.
// done pulses one cycle after the last step, with the quotient held until the next start.
module seq_divider #(
    parameter int DVD_W = 21,
    parameter int DVS_W = 12,
    parameter int QUO_W = 9
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             done,
    output logic [QUO_W-1:0] quotient
);

    localparam int CNT_W = $clog2(DVD_W + 1);

    // Dividend bits shift out of the top while quotient bits shift into the bottom.
    logic [DVD_W-1:0] dvd_q, dvd_d, src_dvd;
    logic [DVS_W:0]   rem_q, rem_d, src_rem, trial;
    logic [DVS_W-1:0] dvs_q, dvs_d, src_dvs;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             done_q, done_d;

    always_comb begin
        src_dvd = start ? dividend : dvd_q;
        src_rem = start ? '0 : rem_q;
        src_dvs = start ? divisor : dvs_q;
        trial   = {src_rem[DVS_W-1:0], src_dvd[DVD_W-1]};
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        done_d  = 1'b0;
        if (start || run_q) begin
            dvs_d = src_dvs;
            if (trial >= {1'b0, src_dvs}) begin
                rem_d = trial - {1'b0, src_dvs};
                dvd_d = {src_dvd[DVD_W-2:0], 1'b1};
            end else begin
                rem_d = trial;
                dvd_d = {src_dvd[DVD_W-2:0], 1'b0};
            end
            cnt_d = start ? CNT_W'(1) : cnt_q + CNT_W'(1);
            run_d = 1'b1;
            if (cnt_d == CNT_W'(DVD_W)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dvd_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            dvd_q  <= dvd_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done     = done_q;
    assign quotient = dvd_q[QUO_W-1:0];

endmodule

// File: rtl/volt_sample_sequencer.sv
// Periodically requests ADC samples, averages a batch, scales it to volts and
// publishes three BCD digits. Valid/ready-free: adc_req is held until a one-cycle adc_ack.
module volt_sample_sequencer #(
    parameter int TICK_DIV    = 50000,
    parameter int AVG_LOG2    = 3,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic        adc_req,
    input  logic        adc_ack,
    input  logic [11:0] adc_data,
    output logic [3:0]  dig1,
    output logic [3:0]  dig01,
    output logic [3:0]  dig001,
    output logic        digits_valid,
    output logic        busy,
    output logic        ack_err,
    output logic [2:0]  dbg_state
);

    import volt_pkg::*;

    localparam int TICK_W = $clog2(TICK_DIV + 1);
    localparam int TMO_W  = $clog2(ACK_TIMEOUT + 1);
    localparam int CNT_W  = AVG_LOG2 + 1;
    localparam int ACC_W  = 15;

    state_e             state_q, state_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [ACC_W-1:0]   acc_q, acc_d, acc_sum;
    logic               div_start_q, div_start_d;
    logic [8:0]         bcd_val_q, bcd_val_d;
    logic [3:0]         bcd_h_q, bcd_h_d, bcd_t_q, bcd_t_d;
    logic [3:0]         dig1_q, dig1_d, dig01_q, dig01_d, dig001_q, dig001_d;
    logic               digits_valid_q, digits_valid_d;
    logic               busy_q, busy_d;
    logic               ack_err_q, ack_err_d;
    logic               adc_req_q, adc_req_d;
    logic [11:0]        avg;
    logic [DIV_STEPS-1:0] dividend;
    logic               div_done;
    logic [8:0]         div_quot;

    assign avg      = 12'(acc_q >> AVG_LOG2);
    assign dividend = DIV_STEPS'(avg) * DIV_STEPS'(SCALE_MUL);

    seq_divider #(.DVD_W(DIV_STEPS), .DVS_W(12), .QUO_W(9)) u_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (div_start_q),
        .dividend (dividend),
        .divisor  (12'(SCALE_DIV)),
        .done     (div_done),
        .quotient (div_quot)
    );

    always_comb begin
        state_d        = state_q;
        tick_d         = tick_q;
        tmo_d          = tmo_q;
        cnt_d          = cnt_q;
        acc_d          = acc_q;
        div_start_d    = 1'b0;
        bcd_val_d      = bcd_val_q;
        bcd_h_d        = bcd_h_q;
        bcd_t_d        = bcd_t_q;
        dig1_d         = dig1_q;
        dig01_d        = dig01_q;
        dig001_d       = dig001_q;
        digits_valid_d = 1'b0;
        ack_err_d      = ack_err_q;
        adc_req_d      = adc_req_q;
        acc_sum        = acc_q + ACC_W'(adc_data);
        cnt_inc        = cnt_q + CNT_W'(1);
        case (state_q)
            ST_IDLE: begin
                tick_d = '0;
                acc_d  = '0;
                cnt_d  = '0;
                if (enable) state_d = ST_WAIT_TICK;
            end
            ST_WAIT_TICK: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    tick_d  = '0;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else if (tick_q == TICK_W'(TICK_DIV - 1)) begin
                    state_d   = ST_REQ;
                    tick_d    = '0;
                    tmo_d     = '0;
                    adc_req_d = 1'b1;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            ST_REQ: begin
                // A request already on the wire completes even if enable drops.
                if (adc_ack) begin
                    adc_req_d = 1'b0;
                    if (!enable) begin
                        state_d = ST_IDLE;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        acc_d = acc_sum;
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_W'(1 << AVG_LOG2)) begin
                            state_d     = ST_DIV;
                            div_start_d = 1'b1;
                        end else begin
                            state_d = ST_WAIT_TICK;
                        end
                    end
                end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
                    state_d   = ST_WAIT_TICK;
                    adc_req_d = 1'b0;
                    ack_err_d = 1'b1;
                    acc_d     = '0;
                    cnt_d     = '0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    state_d   = ST_BCD;
                    bcd_val_d = div_quot;
                    bcd_h_d   = '0;
                    bcd_t_d   = '0;
                end
            end
            ST_BCD: begin
                if (bcd_val_q >= 9'd100) begin
                    bcd_val_d = bcd_val_q - 9'd100;
                    bcd_h_d   = bcd_h_q + 4'd1;
                end else if (bcd_val_q >= 9'd10) begin
                    bcd_val_d = bcd_val_q - 9'd10;
                    bcd_t_d   = bcd_t_q + 4'd1;
                end else begin
                    state_d        = ST_PUBLISH;
                    dig1_d         = bcd_h_q;
                    dig01_d        = bcd_t_q;
                    dig001_d       = bcd_val_q[3:0];
                    digits_valid_d = 1'b1;
                end
            end
            ST_PUBLISH: begin
                acc_d   = '0;
                cnt_d   = '0;
                state_d = enable ? ST_WAIT_TICK : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = !(state_d == ST_IDLE || state_d == ST_WAIT_TICK);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            tick_q         <= '0;
            tmo_q          <= '0;
            cnt_q          <= '0;
            acc_q          <= '0;
            div_start_q    <= 1'b0;
            bcd_val_q      <= '0;
            bcd_h_q        <= '0;
            bcd_t_q        <= '0;
            dig1_q         <= '0;
            dig01_q        <= '0;
            dig001_q       <= '0;
            digits_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            ack_err_q      <= 1'b0;
            adc_req_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            tick_q         <= tick_d;
            tmo_q          <= tmo_d;
            cnt_q          <= cnt_d;
            acc_q          <= acc_d;
            div_start_q    <= div_start_d;
            bcd_val_q      <= bcd_val_d;
            bcd_h_q        <= bcd_h_d;
            bcd_t_q        <= bcd_t_d;
            dig1_q         <= dig1_d;
            dig01_q        <= dig01_d;
            dig001_q       <= dig001_d;
            digits_valid_q <= digits_valid_d;
            busy_q         <= busy_d;
            ack_err_q      <= ack_err_d;
            adc_req_q      <= adc_req_d;
        end
    end

    assign adc_req      = adc_req_q;
    assign dig1         = dig1_q;
    assign dig01        = dig01_q;
    assign dig001       = dig001_q;
    assign digits_valid = digits_valid_q;
    assign busy         = busy_q;
    assign ack_err      = ack_err_q;
    assign dbg_state    = state_q;

endmodule
